// File: rtl/axi_channel_mask_split.sv
// axi_channel_mask_split: buffered valid/ready fan-out with per-beat destination mask
module axi_channel_mask_split #(
    parameter int N_OUTPUTS   = 2,
    parameter int PAYLD_WIDTH = 8,
    parameter int DEPTH       = 2,
    parameter int FILL_W      = $clog2(DEPTH + 1)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   valid_src,
    input  logic [PAYLD_WIDTH-1:0] payload_src,
    input  logic [N_OUTPUTS-1:0]   mask_src,
    output logic                   ready_src,
    output logic [N_OUTPUTS-1:0]   valid_dst,
    output logic [PAYLD_WIDTH-1:0] payload_dst,
    input  logic [N_OUTPUTS-1:0]   ready_dst,
    output logic [FILL_W-1:0]      fill_level,
    output logic                   drop_pulse
);
    localparam int AW = $clog2(DEPTH);

    logic [PAYLD_WIDTH-1:0] pay_mem [DEPTH];
    logic [N_OUTPUTS-1:0]   mask_mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [FILL_W-1:0]      count;
    logic [N_OUTPUTS-1:0]   done, head_mask, hs;
    logic                   rst_done, accept, store, non_empty, retire;

    // Source side is gated only by registered state; a retire in the same cycle never frees space early.
    always_comb begin
        ready_src   = rst_done & (count != FILL_W'(DEPTH));
        accept      = valid_src & ready_src;
        store       = accept & (|mask_src);
        non_empty   = count != '0;
        head_mask   = mask_mem[rd_ptr];
        valid_dst   = {N_OUTPUTS{non_empty}} & head_mask & ~done;
        payload_dst = pay_mem[rd_ptr];
        hs          = valid_dst & ready_dst;
        retire      = non_empty & ((head_mask & ~done & ~hs) == '0);
        fill_level  = count;
    end

    // Storage array; zero-mask beats are never written.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pay_mem[i]  <= '0;
                mask_mem[i] <= '0;
            end
        end else if (store) begin
            pay_mem[wr_ptr]  <= payload_src;
            mask_mem[wr_ptr] <= mask_src;
        end
    end

    // Pointers, occupancy, head done-vector, drop indication and reset-release flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done       <= '0;
            drop_pulse <= 1'b0;
            rst_done   <= 1'b0;
        end else begin
            rst_done   <= 1'b1;
            drop_pulse <= accept & ~(|mask_src);
            wr_ptr     <= store ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= retire ? rd_ptr + AW'(1) : rd_ptr;
            count      <= count + FILL_W'(store) - FILL_W'(retire);
            done       <= retire ? '0 : (done | hs);
        end
    end
endmodule

// File: doc/axi_channel_mask_split.md
# axi_channel_mask_split

Parametrised successor to the two-output AXI channel splitter. It takes one AXI-style valid/ready source channel whose beats each carry a destination mask, and buffers them in a DEPTH-entry FIFO. It fans each beat out to N_OUTPUTS destinations, and each selected destination handshakes independently. A beat retires only when every destination selected by its mask has accepted it. The block sits where one stream feeds several consumers selectively (unicast, multicast, broadcast) and the source must be isolated from destination back-pressure.

## Interface
Parameters:
- N_OUTPUTS, 2, number of destination channels (1..32)
- PAYLD_WIDTH, 8, payload width in bits
- DEPTH, 2, FIFO entries; power of two, at least 2
- FILL_W, $clog2(DEPTH+1), width of fill_level

Ports (one clock; reset is asynchronous and active-low):
- aclk  in  1  clock; all logic on the rising edge
- aresetn  in  1  asynchronous active-low reset
- valid_src  in  1  source beat valid
- payload_src  in  PAYLD_WIDTH  source payload
- mask_src  in  N_OUTPUTS  destination select for the beat; bit i targets output i
- ready_src  out  1  source ready
- valid_dst  out  N_OUTPUTS  per-destination valid
- payload_dst  out  PAYLD_WIDTH  head payload, shared by all destinations
- ready_dst  in  N_OUTPUTS  per-destination ready
- fill_level  out  FILL_W  stored entries, 0..DEPTH
- drop_pulse  out  1  one-cycle pulse; a zero-mask beat was accepted and discarded

## Operation
- Storage: DEPTH entries, each holding {payload, mask}, with a write pointer, a read pointer and a count. Pointers wrap modulo DEPTH.
- Input acceptance: a beat is accepted when valid_src & ready_src.
  - ready_src = rst_done & (count != DEPTH).
  - ready_src is a function of registers only; there is no combinational path from ready_dst or valid_src.
- Zero mask: an accepted beat with mask_src == 0 is not written to storage. drop_pulse is high the following cycle.
- Head state: head mask M and per-output done vector D (register, N_OUTPUTS bits).
- Outputs: valid_dst[i] = (count != 0) & M[i] & ~D[i]. payload_dst = head payload.
- Handshake: hs[i] = valid_dst[i] & ready_dst[i]. On each edge, D |= hs.
- Retire condition: (M & ~D & ~hs) == 0 while count != 0. On retire:
  - D is cleared to 0.
  - The read pointer advances.
  - The next entry becomes head on the following cycle.
- Count update:
  - count increments on a storing write (accept with nonzero mask).
  - count decrements on retire.
  - Both in the same cycle leaves count unchanged.
  - fill_level = count.
- AXI rules:
  - Once valid_dst[i] rises, it stays high and payload_dst stays stable until hs[i].
  - valid_dst[i] never depends combinationally on ready_dst[i].
- Order: beats retire in acceptance order. A slow destination blocks all later beats (head-of-line).

## Timing
- Reset (aresetn low), all asynchronous:
  - count, pointers, D and drop_pulse go to 0.
  - Storage entries go to 0.
  - rst_done goes to 0.
  - Resulting outputs: valid_dst = 0, payload_dst = 0, fill_level = 0, ready_src = 0.
- rst_done is set on the first rising edge after aresetn deasserts, so ready_src = 1 from the second cycle after release.
- Latency: a beat accepted at edge k drives valid_dst at cycle k+1 (1-cycle minimum latency).
- Throughput: one beat per cycle sustained when all selected destinations are ready.
- Full: with count == DEPTH, ready_src = 0 even if a retire happens in the same cycle. Space reappears the cycle after the retire.
- Empty: a write and an empty FIFO in the same cycle give no bypass; valid_dst rises the next cycle.
- Partial acceptance: destinations that have already handshaken see valid_dst low until the next head arrives. D is held across any number of stall cycles.
- Mid-operation reset: all in-flight beats and done state are discarded immediately; there is no output glitch beyond the asynchronous drop to 0.

## Test plan
- Broadcast: N_OUTPUTS=2, DEPTH=2. Send beats 0xA1, 0xA2 with mask 2'b11, all ready_dst = 1 -> each output sees 0xA1 at cycle k+1 and 0xA2 at k+2; fill_level returns to 0.
- Staggered accept: mask 2'b11, ready_dst = 2'b01 for 3 cycles, then 2'b10 -> output 0 handshakes once and drops valid; output 1 handshakes on cycle 4; retire happens then, and no duplicate beat reaches output 0.
- Unicast/multicast mix: N_OUTPUTS=4. Masks 4'b0001, 4'b0110, 4'b1000 -> each payload appears only on the selected outputs, in order.
- Full back-pressure: DEPTH=4, all ready_dst = 0, 6 source beats offered -> 4 accepted, ready_src low, fill_level = 4. Release ready -> remaining 2 accepted in order, no loss.
- Zero mask: beat 0x55 with mask 0 between two normal beats -> drop_pulse high for exactly 1 cycle, 0x55 never seen on outputs, fill_level unchanged by that beat.
- Reset: assert aresetn low while fill_level = 3 and partial D is set -> all outputs 0 asynchronously; after release ready_src = 0 for 1 cycle, then 1; the first new beat is delivered correctly.
